// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding and the bit-counter width rule.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Gate-level 1-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic x1,
    input  logic x2,
    input  logic in_c,
    output logic s,
    output logic out_c
);

    logic p;
    logic g;
    logic t;

    xor g_p   (p, x1, x2);
    xor g_s   (s, p, in_c);
    and g_g   (g, x1, x2);
    and g_t   (t, p, in_c);
    or  g_c   (out_c, g, t);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell, LSB first, WIDTH bit-cycles.
// Subtraction is compiled in only when SERIAL_ADD_CTRL_SUB_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH);
    localparam logic [CW-1:0]  LAST_M1 = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             sub;
    logic             accept;
    logic             step;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    assign sub = op;
`else
    logic unused_op;
    assign unused_op = op;
    assign sub       = 1'b0;
`endif

    // A start seen in RUN is dropped, never queued.
    assign accept = start && (state_q != ST_RUN);
    assign step   = (state_q == ST_RUN) && (cnt_q != LAST);

    fa_cell u_fa (
        .x1    (a_sh[0]),
        .x2    (b_sh[0]),
        .in_c  (carry_q),
        .s     (fa_s),
        .out_c (fa_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_sh    <= a;
            b_sh    <= sub ? ~b : b;
            carry_q <= sub;
        end else if (step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            carry_q <= fa_c;
            cnt_q   <= cnt_q + CW'(1);
            // Flags come from the MSB cell: carry in vs. carry out.
            if (cnt_q == LAST_M1) begin
                cout_q <= fa_c;
                ovf_q  <= carry_q ^ fa_c;
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port op, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-006 SHALL have ports a and b, input, WIDTH bits each: operands, sampled on the accept cycle only.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking the result valid.
REQ-009 SHALL have port sum, output, WIDTH bits: the result.
REQ-010 SHALL have ports cout and ovf, output, 1 bit each: unsigned carry-out and signed overflow.

Function
REQ-011 SHALL use one 1-bit full-adder cell, driven over WIDTH cycles, LSB first.
REQ-012 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE (accept cycle); in both, state goes to RUN, a/b/op latch, the bit counter clears and busy rises.
REQ-014 SHALL hold the carry flip-flop at op on the accept cycle (0 add, 1 subtract), with b inverted when op = 1.
REQ-015 SHALL, in RUN, do one bit per cycle: feed operand shift-register LSBs and carry to the cell, shift the sum bit in at the MSB, update carry and increment the counter.
REQ-016 SHALL leave RUN after exactly WIDTH bit-cycles; the DONE state is entered WIDTH+1 cycles after the accept edge.
REQ-017 SHALL, in DONE, assert done for exactly one cycle with busy low, then go to IDLE unless start is high.
REQ-018 SHALL hold sum, cout and ovf stable from DONE until the next accept; they are undefined while busy.
REQ-019 SHALL set cout to the final carry and ovf to (carry into MSB) XOR (carry out of MSB).
REQ-020 SHALL ignore start while in RUN; no queuing and no restart.
REQ-021 SHALL treat WIDTH-bit arithmetic as modulo 2^WIDTH; for subtract, cout = 1 means no borrow.

Reset
REQ-022 SHALL, while rst_n is low at a clock edge, force: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, counter 0, carry 0.
REQ-023 SHALL abort an operation in progress on reset with no done pulse, and ignore start in the reset cycle.

Configuration
REQ-024 SHALL support the macro SERIAL_ADD_CTRL_SUB_EN: when defined, op is honoured as in REQ-005/REQ-014.
REQ-025 SHALL, when SERIAL_ADD_CTRL_SUB_EN is undefined, ignore op (always add, carry-in 0, b not inverted) and keep the port list unchanged.

Structure
REQ-026 SHALL place the state encoding (IDLE/RUN/DONE) and the counter-width rule ($clog2(WIDTH+1)) in a shared package serial_add_pkg.
REQ-027 SHALL instantiate exactly one sub-module, fa_cell (inputs x1, x2, in_c; outputs s, out_c), as a gate-level full adder.

Verification
REQ-028 SHALL cover: WIDTH=16, add 0x1234 + 0x0FFF -> done 17 cycles after accept, sum 0x2233, cout 0, ovf 0.
REQ-029 SHALL cover: add 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0; and add 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1.
REQ-030 SHALL cover, with SUB_EN defined: subtract 0x0005 - 0x0007 -> sum 0xFFFE, cout 0, ovf 0; without SUB_EN, same stimulus -> sum 0x000C.
REQ-031 SHALL cover: start pulsed mid-RUN -> ignored, result and timing unchanged; start held in DONE -> back-to-back accept, done again 17 cycles later.
REQ-032 SHALL cover: rst_n low at bit-cycle 8 -> next cycle busy 0, done never pulses, sum 0x0000; a new start after release completes correctly.
